inst_queue: RTL



---
 rtl/inst_queue_pkg.sv | 25 ++
 rtl/queue_ram.sv | 30 +++
 rtl/inst_queue.sv | 96 +++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the fetch-to-issue instruction queue.
//   INST_W_DEF / ADDR_W_DEF : default instruction and pc widths
//   entry_t                 : one queue entry {inst, addr} at default widths
//   ptr_w / cnt_w           : pointer and occupancy-counter widths for a depth
package inst_queue_pkg;

    localparam int INST_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [ADDR_W_DEF-1:0] addr;
    } entry_t;

    // Pointer width; depth is a power of two so pointers wrap naturally.
    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Counter needs one extra bit to represent a completely full queue.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/queue_ram.sv
// Entry storage for inst_queue: DEPTH x W, synchronous write, asynchronous
// read so the head entry can be presented first-word-fall-through.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational)
module queue_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);

    // Data is never reset; validity is tracked by the queue's count.
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Instruction/pc queue between fetch and issue.
//   clk_in, rst_in      : clock, synchronous active-high reset
//   rdy_in              : global ready; low freezes all state
//   _clear              : flush on mispredict
//   _inst_ready_in,
//   _inst_in, _inst_addr: push strobe and entry from fetch
//   _pop                : issue consumes the head entry
//   _top_*              : head entry, first-word-fall-through
//   _full/_almost_full/_empty/_count : occupancy status from registered count
//   _overflow           : sticky, a push was dropped because the queue was full
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int INST_W   = INST_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int AFULL_TH = DEPTH - 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      _clear,
    input  logic                      _inst_ready_in,
    input  logic [INST_W-1:0]         _inst_in,
    input  logic [ADDR_W-1:0]         _inst_addr,
    input  logic                      _pop,
    output logic                      _top_valid,
    output logic [INST_W-1:0]         _top_inst,
    output logic [ADDR_W-1:0]         _top_inst_addr,
    output logic                      _full,
    output logic                      _almost_full,
    output logic                      _empty,
    output logic [cnt_w(DEPTH)-1:0]   _count,
    output logic                      _overflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int EW = INST_W + ADDR_W;

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic          overflow;
    logic          pop_ok, push_ok, wr_en;
    logic [EW-1:0] head_entry;

    assign _empty       = (count == '0);
    assign _full        = (count == CW'(DEPTH));
    assign _almost_full = (count >= CW'(AFULL_TH));
    assign _top_valid   = !_empty;
    assign _count       = count;
    assign _overflow    = overflow;

    assign pop_ok  = _pop & !_empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok = _inst_ready_in & (!_full | pop_ok);
    // Storage write must obey the same priority as the pointer update.
    assign wr_en   = !rst_in & rdy_in & !_clear & push_ok;

    queue_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
        .clk   (clk_in),
        .we    (wr_en),
        .waddr (tail),
        .wdata ({_inst_in, _inst_addr}),
        .raddr (head),
        .rdata (head_entry)
    );

    assign {_top_inst, _top_inst_addr} = head_entry;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (rdy_in) begin
            if (_clear) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                overflow <= 1'b0;
            end else begin
                if (push_ok) tail <= tail + PW'(1);
                if (pop_ok)  head <= head + PW'(1);
                case ({push_ok, pop_ok})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (_inst_ready_in && !push_ok) overflow <= 1'b1;
            end
        end
    end

endmodule
